// File: rtl/wb_arb_pkg.sv
// Shared types, defaults and sizing helper for the Wishbone master arbiter.
package wb_arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUS  = 1'b1
    } state_t;

    localparam int DEFAULT_NUM_REQ = 32'sd4;
    localparam int DEFAULT_TIMEOUT = 32'sd255;

    // Bits needed to hold any value in 0..max_val (never less than one).
    function automatic int cnt_width(input int max_val);
        int w;
        w = 32'sd1;
        for (int i = 32'sd1; i < 32'sd31; i++) begin
            if ((max_val >>> i) != 32'sd0) begin
                w = i + 32'sd1;
            end else begin
                w = w;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/wb_master_arbiter_rr_arb_pick.sv
// Combinational round-robin picker: first set request after 'last', with wrap.
module rr_arb_pick
    import wb_arb_pkg::*;
#(
    parameter int NUM_REQ = DEFAULT_NUM_REQ,
    parameter int IDX_W   = cnt_width(NUM_REQ - 32'sd1)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [NUM_REQ-1:0] gnt,
    output logic               valid
);

    logic [IDX_W-1:0] idx_s;

    // Scan last+1 .. last+NUM_REQ; the owner that just finished is checked last.
    always_comb begin
        gnt   = '0;
        valid = 1'b0;
        idx_s = '0;
        for (int i = 32'sd1; i <= NUM_REQ; i++) begin
            idx_s = IDX_W'((int'(last) + i) % NUM_REQ);
            if (req[idx_s] && !valid) begin
                gnt[idx_s] = 1'b1;
                valid      = 1'b1;
            end else begin
                valid = valid;
            end
        end
    end

endmodule

// File: rtl/wb_master_arbiter.sv
// Round-robin Wishbone classic master shared by NUM_REQ requesters, with ack timeout.
// Optional sticky timeout interrupt (irq_o/irq_clr_i) when TIMEOUT_IRQ_EN is defined.
module wb_master_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NUM_REQ     = DEFAULT_NUM_REQ,
    parameter int ADDR_W      = 32'sd32,
    parameter int DATA_W      = 32'sd32,
    parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT
) (
    input  logic                          wb_clk_i,
    input  logic                          wb_rst_i,
    input  logic                          ncs,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [NUM_REQ-1:0]            req_we_i,
    input  logic [NUM_REQ*ADDR_W-1:0]     req_adr_i,
    input  logic [NUM_REQ*DATA_W-1:0]     req_dat_i,
    input  logic [NUM_REQ*(DATA_W/8)-1:0] req_sel_i,
    output logic [NUM_REQ-1:0]            gnt_o,
    output logic [NUM_REQ-1:0]            done_o,
    output logic [NUM_REQ-1:0]            err_o,
    output logic [DATA_W-1:0]             rdata_o,
    output logic                          wbm_cyc_o,
    output logic                          wbm_stb_o,
    output logic                          wbm_we_o,
    output logic [ADDR_W-1:0]             wbm_adr_o,
    output logic [DATA_W-1:0]             wbm_dat_o,
    output logic [DATA_W/8-1:0]           wbm_sel_o,
    input  logic [DATA_W-1:0]             wbm_dat_i,
    input  logic                          wbm_ack_i
`ifdef TIMEOUT_IRQ_EN
    ,
    output logic                          irq_o,
    input  logic                          irq_clr_i
`endif
);

    localparam int SEL_W = DATA_W / 32'sd8;
    localparam int IDX_W = cnt_width(NUM_REQ - 32'sd1);
    localparam int CNT_W = cnt_width(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 32'sd1);

    state_t               state_r;
    logic [IDX_W-1:0]     last_r;
    logic [IDX_W-1:0]     owner_r;
    logic [CNT_W-1:0]     cnt_r;
    logic [NUM_REQ-1:0]   pick_gnt_s;
    logic                 pick_valid_s;
    logic [IDX_W-1:0]     pick_idx_s;

    rr_arb_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req   (req_i),
        .last  (last_r),
        .gnt   (pick_gnt_s),
        .valid (pick_valid_s)
    );

    // One-hot winner to index, used to slice the packed payload buses.
    always_comb begin
        pick_idx_s = '0;
        for (int k = 32'sd0; k < NUM_REQ; k++) begin
            if (pick_gnt_s[k]) begin
                pick_idx_s = IDX_W'(k);
            end else begin
                pick_idx_s = pick_idx_s;
            end
        end
    end

    // Grant / bus-cycle FSM; payload is latched at grant so requesters cannot disturb it.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_r   <= IDLE;
            last_r    <= IDX_W'(NUM_REQ - 32'sd1);
            owner_r   <= '0;
            cnt_r     <= '0;
            gnt_o     <= '0;
            done_o    <= '0;
            err_o     <= '0;
            rdata_o   <= '0;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
            wbm_sel_o <= '0;
        end else begin
            done_o <= '0;
            err_o  <= '0;
            case (state_r)
                IDLE: begin
                    cnt_r <= '0;
                    if (!ncs && pick_valid_s) begin
                        state_r   <= BUS;
                        gnt_o     <= pick_gnt_s;
                        owner_r   <= pick_idx_s;
                        wbm_cyc_o <= 1'b1;
                        wbm_stb_o <= 1'b1;
                        wbm_we_o  <= req_we_i[pick_idx_s];
                        wbm_adr_o <= req_adr_i[int'(pick_idx_s)*ADDR_W +: ADDR_W];
                        wbm_dat_o <= req_dat_i[int'(pick_idx_s)*DATA_W +: DATA_W];
                        wbm_sel_o <= req_sel_i[int'(pick_idx_s)*SEL_W +: SEL_W];
                    end else begin
                        state_r <= IDLE;
                    end
                end
                BUS: begin
                    if (wbm_ack_i) begin
                        if (!wbm_we_o) begin
                            rdata_o <= wbm_dat_i;
                        end else begin
                            rdata_o <= rdata_o;
                        end
                        done_o    <= gnt_o;
                        last_r    <= owner_r;
                        gnt_o     <= '0;
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        cnt_r     <= '0;
                        state_r   <= IDLE;
                    end else if (cnt_r == CNT_LAST) begin
                        err_o     <= gnt_o;
                        last_r    <= owner_r;
                        gnt_o     <= '0;
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        cnt_r     <= '0;
                        state_r   <= IDLE;
                    end else begin
                        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    gnt_o     <= '0;
                    wbm_cyc_o <= 1'b0;
                    wbm_stb_o <= 1'b0;
                end
            endcase
        end
    end

`ifdef TIMEOUT_IRQ_EN
    // Sticky timeout flag; a new err pulse beats a simultaneous clear.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            irq_o <= 1'b0;
        end else if (|err_o) begin
            irq_o <= 1'b1;
        end else if (irq_clr_i) begin
            irq_o <= 1'b0;
        end else begin
            irq_o <= irq_o;
        end
    end
`endif

endmodule
